// File: rtl/mac_seq.sv
// mac_seq: beat sequencer in front of an external pipelined MAC.
// Streams (in_a, in_b) beats into the MAC and returns each job's dot product.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-low reset
//   in_a/in_b  8-bit unsigned operands of the offered beat
//   in_valid   beat offered
//   in_last    offered beat closes the current dot-product job
//   in_ready   beat accepted on in_valid & in_ready (high only in STREAM)
//   a/b        registered operands to the MAC
//   mult_en    registered MAC multiply enable
//   acc_en     registered MAC accumulate enable (mult_en delayed one cycle)
//   mac_clr    active-high clear to the MAC
//   acc_out    MAC accumulator value
//   res_data   captured dot-product result
//   res_valid  result available, held until res_ready
//   res_ready  result consumed on res_valid & res_ready
//   res_count  beat count of the job (only with MAC_SEQ_CNT_EN)
//
// Build option: define MAC_SEQ_CNT_EN to add the res_count output.
module mac_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       a,
    output logic [7:0]       b,
    output logic             mult_en,
    output logic             acc_en,
    output logic             mac_clr,
    input  logic [31:0]      acc_out,
    output logic [31:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready
`ifdef MAC_SEQ_CNT_EN
    ,
    output logic [CNT_W-1:0] res_count
`endif
);

    typedef enum logic [1:0] {
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    state_t     state;
    logic [1:0] drain_cnt;
    logic       accept;

    // in_ready is a register that tracks state == STREAM exactly.
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= CLEAR;
            in_ready  <= 1'b0;
            mac_clr   <= 1'b1;
            a         <= '0;
            b         <= '0;
            mult_en   <= 1'b0;
            acc_en    <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            drain_cnt <= '0;
        end else begin
            // One product per accepted beat; acc_en follows one cycle
            // later so each product is summed exactly once.
            mult_en <= accept;
            acc_en  <= mult_en;
            if (accept) begin
                a <= in_a;
                b <= in_b;
            end

            unique case (state)
                CLEAR: begin
                    mac_clr   <= 1'b0;
                    in_ready  <= 1'b1;
                    drain_cnt <= '0;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (accept && in_last) begin
                        in_ready  <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last product lands in the accumulator two edges
                    // after its accept; capture on the third.
                    if (drain_cnt == 2'd2) begin
                        res_data  <= acc_out;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        mac_clr   <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

`ifdef MAC_SEQ_CNT_EN
    logic [CNT_W-1:0] beat_cnt;

    // Accepted-beat count per job; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt  <= '0;
            res_count <= '0;
        end else begin
            if (state == CLEAR) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == DRAIN && drain_cnt == 2'd2) begin
                res_count <= beat_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: scoreboard bench for mac_seq with a behavioural MAC model.
// Driver pushes hand-computed results; a negedge monitor pops and compares.
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_a, in_b;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  a, b;
    logic        mult_en, acc_en, mac_clr;
    logic [31:0] acc_out;
    logic [31:0] res_data;
    logic        res_valid, res_ready;
`ifdef MAC_SEQ_CNT_EN
    logic [15:0] res_count;
`endif

    always #5 clk = ~clk;

    mac_seq #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .a(a), .b(b), .mult_en(mult_en), .acc_en(acc_en),
        .mac_clr(mac_clr), .acc_out(acc_out),
        .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready)
`ifdef MAC_SEQ_CNT_EN
        , .res_count(res_count)
`endif
    );

    // Pipelined MAC: product register, then accumulator.
    logic [15:0] prod;
    logic [31:0] acc;
    always @(posedge clk) begin
        if (mac_clr) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mult_en) prod <= 16'(a) * 16'(b);
            if (acc_en)  acc  <= acc + {16'b0, prod};
        end
    end
    assign acc_out = acc;

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   clr_hi = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mac_clr) clr_hi++;
        if (reset && res_valid) begin
            if (!prev_valid) check("latency", 32'(cyc - last_acc), 32'd3);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_res actual=%0d required=none",
                         res_data);
            end else begin
                check("res_data", res_data, exp_q[0].data);
`ifdef MAC_SEQ_CNT_EN
                check("res_count", {16'b0, res_count},
                      {16'b0, exp_q[0].cnt});
`endif
                if (res_ready) void'(exp_q.pop_front());
            end
        end
        prev_valid = reset && res_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        in_last = 1'($urandom);
    endtask

    task automatic send_beat(input logic [7:0] x, input logic [7:0] y,
                             input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_a     = x;
        in_b     = y;
        in_last  = last;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            last_acc = cyc + 1;
            step();
        end
        in_valid = 1'b0;
        garbage();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout actual=%0d required=0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_job(input int n,
                           input logic [7:0] av [4],
                           input logic [7:0] bv [4],
                           input bit gaps,
                           input logic [31:0] expd,
                           input bit wait_done);
        exp_t e;
        e.data = expd;
        e.cnt  = 16'(n);
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_beat(av[i], bv[i], i == n - 1);
            if (gaps && i != n - 1)
                repeat ((i % 3) + 1) step();
        end
        // Offers while not ready must be ignored.
        in_valid = 1'b1;
        garbage();
        step();
        step();
        in_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mac_clr", {31'b0, mac_clr}, 32'd1);
        check("rst_a", {24'b0, a}, 32'd0);
        check("rst_b", {24'b0, b}, 32'd0);
        check("rst_mult_en", {31'b0, mult_en}, 32'd0);
        check("rst_acc_en", {31'b0, acc_en}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
`ifdef MAC_SEQ_CNT_EN
        check("rst_res_count", {16'b0, res_count}, 32'd0);
`endif
    endtask

    logic [7:0] va [4];
    logic [7:0] vb [4];

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        repeat (3) step();
        check_reset_vals();
        reset = 1'b1;
        step();
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_mac_clr", {31'b0, mac_clr}, 32'd0);

        // Contiguous beats: 12 + 30 + 56.
        va = '{8'd3, 8'd5, 8'd7, 8'd0};
        vb = '{8'd4, 8'd6, 8'd8, 8'd0};
        run_job(3, va, vb, 1'b0, 32'd98, 1'b1);

        // Same beats with valid bubbles.
        run_job(3, va, vb, 1'b1, 32'd98, 1'b1);

        // Maximum operands: 4 * 65025.
        va = '{8'd255, 8'd255, 8'd255, 8'd255};
        vb = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_job(4, va, vb, 1'b0, 32'd260100, 1'b1);

        // Back-pressured result, then a fresh job.
        step();
        step();
        clr_hi = 0;
        res_ready = 1'b0;
        va = '{8'd10, 8'd0, 8'd0, 8'd0};
        vb = '{8'd20, 8'd0, 8'd0, 8'd0};
        run_job(1, va, vb, 1'b0, 32'd200, 1'b0);
        begin
            int t = 0;
            while (!res_valid && t < 50) begin
                step();
                t++;
            end
        end
        check("hold_valid", {31'b0, res_valid}, 32'd1);
        repeat (5) step();
        check("hold_valid_5", {31'b0, res_valid}, 32'd1);
        check("hold_data_5", res_data, 32'd200);
        res_ready = 1'b1;
        wait_idle();
        va = '{8'd1, 8'd0, 8'd0, 8'd0};
        vb = '{8'd1, 8'd0, 8'd0, 8'd0};
        run_job(1, va, vb, 1'b0, 32'd1, 1'b1);
        check("clr_pulses", 32'(clr_hi), 32'd1);

        // Reset in the middle of a job.
        step();
        step();
        send_beat(8'd3, 8'd4, 1'b0);
        send_beat(8'd5, 8'd6, 1'b0);
        reset = 1'b0;
        step();
        step();
        check_reset_vals();
        reset = 1'b1;
        step();
        va = '{8'd2, 8'd0, 8'd0, 8'd0};
        vb = '{8'd3, 8'd0, 8'd0, 8'd0};
        run_job(1, va, vb, 1'b0, 32'd6, 1'b1);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
